uart_regmap_master: RTL and testbench
=====================================

UART_REGMAP_MASTER -- requirements
Module: uart_regmap_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n_sync.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd1_200_000: idle cycles between command bytes before the parser aborts.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n_sync  input  1  async active-low reset.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid.
REQ-007 tx_data  output  8  byte to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data is valid; held until tx_ready.
REQ-009 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-010 address  output  8  regmap address.
REQ-011 trigger_write_enable  output  1  one-cycle write strobe.
REQ-012 write_data_in  output  8  regmap write data.
REQ-013 trigger_read_enable  output  1  one-cycle read strobe.
REQ-014 trigger_read_data  input  8  regmap read data, combinational from address and read enable.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 timeout_pulse  output  1  one-cycle pulse when a command is aborted on timeout; tied 0 when the timeout is compiled out.

Function
REQ-017 Command frame SHALL be:
- byte0: bit7 = 1 for read, 0 for write; bits[6:0] = N-1, where N is the burst length (1..128).
- byte1: start address.
- Write only: N data bytes follow.
REQ-018 State machine SHALL use the states IDLE, GET_ADDR, WR_DATA, RD_REQ and RD_SEND.
REQ-019 IDLE: on rx_valid, latch rw and the count, then go to GET_ADDR.
REQ-020 GET_ADDR: on rx_valid, load address; a write goes to WR_DATA and a read goes to RD_REQ.
REQ-021 WR_DATA: on each rx_valid, in the next cycle drive write_data_in = byte and pulse trigger_write_enable for exactly one cycle at the current address.
- After the strobe, address increments.
- After N strobes, go to IDLE.
REQ-022 RD_REQ: pulse trigger_read_enable for one cycle, capture trigger_read_data into tx_data in that same cycle, assert tx_valid on the next cycle, then go to RD_SEND.
REQ-023 RD_SEND: hold tx_data and tx_valid until tx_ready is sampled high.
- Then deassert tx_valid and increment address.
- Go to RD_REQ if bytes remain, else IDLE.
REQ-024 Address SHALL wrap modulo 256 (8'hFF+1 = 8'h00); the burst counter SHALL NOT wrap.
REQ-025 rx_valid in RD_REQ or RD_SEND SHALL be discarded, with no state effect.
REQ-026 trigger_write_enable and trigger_read_enable SHALL never be high in the same cycle.
REQ-027 Write latency SHALL be 1 cycle from rx_valid to trigger_write_enable.
REQ-028 Read latency SHALL be 1 cycle from trigger_read_enable to tx_valid.

Reset
REQ-029 On reset, all outputs SHALL be 0, the state SHALL be IDLE, and the counters SHALL be 0.
REQ-030 Reset mid-burst SHALL abort immediately: tx_valid drops and no further strobes are issued.

Configuration
REQ-031 With UART_REGMAP_TIMEOUT_EN defined, a counter runs in GET_ADDR and WR_DATA:
- It clears on every rx_valid.
- On reaching TIMEOUT_CYCLES, the FSM returns to IDLE and timeout_pulse pulses for 1 cycle.
REQ-032 Without UART_REGMAP_TIMEOUT_EN, no counter SHALL be built, timeout_pulse SHALL be constant 0, and a partial frame SHALL wait indefinitely.

Structure
REQ-033 Package uart_regmap_pkg SHALL hold:
- the state enum;
- CMD_RW_BIT = 7;
- the CMD_LEN_MSB/LSB constants;
- the TIMEOUT_CYCLES default.
REQ-034 The timeout counter SHALL be a sub-module, uart_rx_timeout, with inputs clk, rst_n_sync, run and clear, and output expired.

Verification
REQ-035 Write 1 byte: send 8'h00, 8'h08, 8'h01 -> one trigger_write_enable at address 8, write_data_in = 8'h01; busy then low.
REQ-036 Read burst: send 8'h88, 8'h00 (N = 9) -> nine tx bytes carrying regmap[0..8] in order, with tx_ready stalled 5 cycles on byte 3 and tx_data stable throughout.
REQ-037 Address wrap: write N = 2 starting at 8'hFF with bytes AA, BB -> strobes at 8'hFF then 8'h00.
REQ-038 rx_valid during RD_SEND -> ignored; no write strobe; the read burst completes normally.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES = 100): send 8'h00 only -> timeout_pulse at idle cycle 100, then IDLE; the next frame is decoded correctly.
REQ-040 Reset asserted during a 4-byte read after byte 2 -> tx_valid = 0 the same cycle, then IDLE, with no further strobes.

Source files
------------

// File: rtl/uart_regmap_pkg.sv
// Shared types and constants for the UART-to-regmap command master.
package uart_regmap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        WR_DATA  = 3'd2,
        RD_REQ   = 3'd3,
        RD_SEND  = 3'd4
    } state_t;

    localparam int CMD_RW_BIT  = 7;
    localparam int CMD_LEN_MSB = 6;
    localparam int CMD_LEN_LSB = 0;

    localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd1_200_000;

endpackage

// File: rtl/uart_rx_timeout.sv
// Idle-gap watchdog: counts run cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES.
module uart_rx_timeout
    import uart_regmap_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n_sync,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [23:0] LAST = TIMEOUT_CYCLES - 24'd1;

    logic [23:0] count;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            count <= '0;
        end else if (!run || clear || expired) begin
            count <= '0;
        end else begin
            count <= count + 24'd1;
        end
    end

    // count holds the number of idle cycles already elapsed, so the current
    // cycle is idle cycle count+1
    assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/uart_regmap_master.sv
// Decodes read/write burst commands from a UART byte stream into regmap
// strobes. Optional idle-gap abort: define UART_REGMAP_TIMEOUT_EN.
module uart_regmap_master
    import uart_regmap_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n_sync,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] address,
    output logic       trigger_write_enable,
    output logic [7:0] write_data_in,
    output logic       trigger_read_enable,
    input  logic [7:0] trigger_read_data,
    output logic       busy,
    output logic       timeout_pulse
);

    state_t     state;
    state_t     next_state;
    logic       rd_mode;
    logic [6:0] cnt;
    logic       expired;

`ifdef UART_REGMAP_TIMEOUT_EN
    logic timer_run;

    assign timer_run = (state == GET_ADDR) || (state == WR_DATA);

    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .run        (timer_run),
        .clear      (rx_valid),
        .expired    (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The last write byte returns to IDLE at once so a following command
    // byte arriving during the final strobe cycle is still decoded.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rx_valid) next_state = GET_ADDR;
            end
            GET_ADDR: begin
                if (expired)       next_state = IDLE;
                else if (rx_valid) next_state = rd_mode ? RD_REQ : WR_DATA;
            end
            WR_DATA: begin
                if (expired)                     next_state = IDLE;
                else if (rx_valid && cnt == 7'd0) next_state = IDLE;
            end
            RD_REQ: begin
                next_state = RD_SEND;
            end
            RD_SEND: begin
                if (tx_ready) next_state = (cnt == 7'd0) ? IDLE : RD_REQ;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy                = (state != IDLE);
        trigger_read_enable = (state == RD_REQ);
        timeout_pulse       = expired;
    end

    // cnt holds bytes remaining minus one and saturates at zero
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rd_mode              <= 1'b0;
            cnt                  <= '0;
            address              <= '0;
            write_data_in        <= '0;
            trigger_write_enable <= 1'b0;
            tx_data              <= '0;
            tx_valid             <= 1'b0;
        end else begin
            trigger_write_enable <= 1'b0;
            if (trigger_write_enable) address <= address + 8'd1;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        rd_mode <= rx_data[CMD_RW_BIT];
                        cnt     <= rx_data[CMD_LEN_MSB:CMD_LEN_LSB];
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) address <= rx_data;
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        write_data_in        <= rx_data;
                        trigger_write_enable <= 1'b1;
                        if (cnt != 7'd0) cnt <= cnt - 7'd1;
                    end
                end
                RD_REQ: begin
                    tx_data  <= trigger_read_data;
                    tx_valid <= 1'b1;
                end
                RD_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        address  <= address + 8'd1;
                        if (cnt != 7'd0) cnt <= cnt - 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_regmap_master.sv
// Randomized self-checking bench for uart_regmap_master against a frame-level
// regmap model; the timeout scenario follows UART_REGMAP_TIMEOUT_EN.
module tb_uart_regmap_master;

    logic       clk = 1'b0;
    logic       rst_n_sync;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] address;
    logic       trigger_write_enable;
    logic [7:0] write_data_in;
    logic       trigger_read_enable;
    logic [7:0] trigger_read_data;
    logic       busy;
    logic       timeout_pulse;

    always #5 clk = ~clk;

    uart_regmap_master #(
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk                  (clk),
        .rst_n_sync           (rst_n_sync),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .address              (address),
        .trigger_write_enable (trigger_write_enable),
        .write_data_in        (write_data_in),
        .trigger_read_enable  (trigger_read_enable),
        .trigger_read_data    (trigger_read_data),
        .busy                 (busy),
        .timeout_pulse        (timeout_pulse)
    );

    // Regmap slave: random power-up contents, overwritten by DUT strobes.
    logic [7:0] seed_mem  [256];
    logic [7:0] slave_mem [256];
    bit         slave_vld [256];
    logic [7:0] ref_mem   [256];

    assign trigger_read_data = trigger_read_enable
                             ? (slave_vld[address] ? slave_mem[address] : seed_mem[address])
                             : 8'h00;

    always @(posedge clk) begin
        if (trigger_write_enable) begin
            slave_mem[address] <= write_data_in;
            slave_vld[address] <= 1'b1;
        end
    end

    logic [15:0] obs_wr[$];
    int both_hi     = 0;
    int tp_count    = 0;
    int rd_en_count = 0;

    always @(negedge clk) begin
        if (rst_n_sync) begin
            if (trigger_write_enable) obs_wr.push_back({address, write_data_in});
            if (trigger_write_enable && trigger_read_enable) both_hi++;
            if (timeout_pulse) tp_count++;
            if (trigger_read_enable) rd_en_count++;
        end
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  frame[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  got[$];
    int          unstable_n;
    int          tmo_n;

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int gap);
        foreach (frame[i]) send_byte(frame[i], gap);
    endtask

    task automatic model_write(input int start, input int n);
        logic [7:0] a;
        logic [7:0] d;
        frame  = {};
        exp_wr = {};
        frame.push_back({1'b0, 7'(n - 1)});
        frame.push_back(8'(start));
        for (int i = 0; i < n; i++) begin
            a = 8'((start + i) % 256);
            d = 8'($urandom);
            frame.push_back(d);
            exp_wr.push_back({a, d});
            ref_mem[a] = d;
        end
    endtask

    task automatic model_read(input int start, input int n);
        frame  = {};
        exp_rd = {};
        frame.push_back({1'b1, 7'(n - 1)});
        frame.push_back(8'(start));
        for (int i = 0; i < n; i++) exp_rd.push_back(ref_mem[8'((start + i) % 256)]);
    endtask

    // Accepts n tx bytes; on byte stall_idx holds tx_ready low for stall_len
    // cycles (optionally injecting one rx byte) and notes any instability.
    task automatic recv_bytes(input int n, input int stall_idx, input int stall_len, input bit inject);
        int         w;
        logic [7:0] held;
        got        = {};
        unstable_n = 0;
        tmo_n      = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            @(negedge clk);
            while (tx_valid !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (tx_valid !== 1'b1) begin
                tmo_n++;
                break;
            end
            held = tx_data;
            if (i == stall_idx) begin
                for (int k = 0; k < stall_len; k++) begin
                    @(posedge clk); #1;
                    rx_valid = inject && (k == 0);
                    rx_data  = 8'($urandom_range(0, 127));
                    @(negedge clk);
                    if (tx_valid !== 1'b1 || tx_data !== held) unstable_n++;
                end
                rx_valid = 1'b0;
            end
            got.push_back(held);
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n_sync = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({tx_data, tx_valid, address, trigger_write_enable, write_data_in,
             trigger_read_enable, busy, timeout_pulse} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got tx_data=%h tx_valid=%b addr=%h we=%b wd=%h re=%b busy=%b tp=%b want all 0",
                     tx_data, tx_valid, address, trigger_write_enable, write_data_in,
                     trigger_read_enable, busy, timeout_pulse);
        end
        @(posedge clk); #1;
        rst_n_sync = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, tx_valid, trigger_write_enable, trigger_read_enable} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b tx_valid=%b we=%b re=%b want 0",
                     busy, tx_valid, trigger_write_enable, trigger_read_enable);
        end
    endtask

    task automatic test_write_single();
        obs_wr = {};
        frame  = {};
        frame.push_back(8'h00);
        frame.push_back(8'h08);
        frame.push_back(8'h01);
        ref_mem[8] = 8'h01;
        send_frame(2);
        repeat (3) @(negedge clk);
        total++;
        if (obs_wr.size() !== 1) begin
            bad++;
            $display("FAIL wr_single_count: got %0d strobes want 1", obs_wr.size());
        end
        if (obs_wr.size() > 0) begin
            total++;
            if (obs_wr[0] !== 16'h0801) begin
                bad++;
                $display("FAIL wr_single_addr_data: got %h want 0801", obs_wr[0]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_single_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_read_burst();
        model_read(0, 9);
        send_frame(1);
        recv_bytes(9, 2, 5, 1'b0);
        total++;
        if (tmo_n !== 0 || got.size() !== 9) begin
            bad++;
            $display("FAIL rd_burst_count: got %0d bytes (timeouts %0d) want 9", got.size(), tmo_n);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) begin
                total++;
                if (got[i] !== exp_rd[i]) begin
                    bad++;
                    $display("FAIL rd_burst_byte%0d: got %h want %h", i, got[i], exp_rd[i]);
                end
            end
        end
        total++;
        if (unstable_n !== 0) begin
            bad++;
            $display("FAIL rd_burst_stall_stable: got %0d unstable cycles want 0", unstable_n);
        end
    endtask

    task automatic test_addr_wrap();
        obs_wr = {};
        frame  = {};
        frame.push_back(8'h01);
        frame.push_back(8'hFF);
        frame.push_back(8'hAA);
        frame.push_back(8'hBB);
        ref_mem[255] = 8'hAA;
        ref_mem[0]   = 8'hBB;
        send_frame(3);
        repeat (3) @(negedge clk);
        total++;
        if (obs_wr.size() !== 2) begin
            bad++;
            $display("FAIL wrap_count: got %0d strobes want 2", obs_wr.size());
        end else begin
            total++;
            if (obs_wr[0] !== 16'hFFAA || obs_wr[1] !== 16'h00BB) begin
                bad++;
                $display("FAIL wrap_addr_data: got %h %h want FFAA 00BB", obs_wr[0], obs_wr[1]);
            end
        end
    endtask

    task automatic test_rx_during_read();
        int start;
        start = $urandom_range(0, 255);
        model_read(start, 4);
        obs_wr = {};
        send_frame(1);
        recv_bytes(4, 1, 4, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (tmo_n !== 0 || got.size() !== 4) begin
            bad++;
            $display("FAIL rxrd_count: got %0d bytes (timeouts %0d) want 4", got.size(), tmo_n);
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== exp_rd[i]) begin
                bad++;
                $display("FAIL rxrd_byte%0d: got %h want %h", i, got[i], exp_rd[i]);
            end
        end
        total++;
        if (obs_wr.size() !== 0 || busy !== 1'b0 || unstable_n !== 0) begin
            bad++;
            $display("FAIL rxrd_ignored: got strobes=%0d busy=%b unstable=%0d want 0 0 0",
                     obs_wr.size(), busy, unstable_n);
        end
    endtask

    task automatic test_timeout();
        int first;
        int npulse;
        int tp0;
        first  = -1;
        npulse = 0;
        tp0    = tp_count;
        send_byte(8'h00, 0);
`ifdef UART_REGMAP_TIMEOUT_EN
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (timeout_pulse === 1'b1) begin
                npulse++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (first !== 100 || npulse !== 1) begin
            bad++;
            $display("FAIL timeout_pulse: got first=%0d count=%0d want 100 1", first, npulse);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: got busy=%b want 0", busy);
        end
        model_write($urandom_range(0, 255), 1);
        obs_wr = {};
        send_frame(2);
`else
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (timeout_pulse === 1'b1) npulse++;
        end
        total++;
        if (npulse !== 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL no_timeout_wait: got pulses=%0d busy=%b want 0 1", npulse, busy);
        end
        model_write($urandom_range(0, 255), 1);
        obs_wr = {};
        send_byte(frame[1], 2);
        send_byte(frame[2], 2);
`endif
        repeat (3) @(negedge clk);
        total++;
        if (obs_wr.size() !== 1 || (obs_wr.size() == 1 && obs_wr[0] !== exp_wr[0])) begin
            bad++;
            $display("FAIL timeout_next_frame: got %0d strobes first=%h want 1 %h",
                     obs_wr.size(), (obs_wr.size() > 0) ? obs_wr[0] : 16'h0, exp_wr[0]);
        end
        total++;
`ifdef UART_REGMAP_TIMEOUT_EN
        if (tp_count - tp0 !== 1) begin
`else
        if (tp_count - tp0 !== 0) begin
`endif
            bad++;
            $display("FAIL timeout_pulse_total: got %0d", tp_count - tp0);
        end
    endtask

    task automatic test_random_frames();
        int start;
        int n;
        int gap;
        for (int it = 0; it < 9; it++) begin
            start = $urandom_range(0, 255);
            n     = (it == 8) ? 128 : $urandom_range(1, 8);
            gap   = $urandom_range(0, 3);
            if (it == 8 || $urandom_range(0, 1) == 0) begin
                model_write(start, n);
                obs_wr = {};
                send_frame(gap);
                repeat (3) @(negedge clk);
                total++;
                if (obs_wr.size() !== exp_wr.size()) begin
                    bad++;
                    $display("FAIL rand_wr%0d_count: got %0d want %0d", it, obs_wr.size(), exp_wr.size());
                end else begin
                    foreach (exp_wr[i]) begin
                        total++;
                        if (obs_wr[i] !== exp_wr[i]) begin
                            bad++;
                            $display("FAIL rand_wr%0d_%0d: got %h want %h", it, i, obs_wr[i], exp_wr[i]);
                        end
                    end
                end
            end else begin
                model_read(start, n);
                send_frame(gap);
                recv_bytes(n, $urandom_range(0, n - 1), $urandom_range(0, 4), 1'b0);
                total++;
                if (got.size() !== n || unstable_n !== 0) begin
                    bad++;
                    $display("FAIL rand_rd%0d_count: got %0d bytes unstable=%0d want %0d 0",
                             it, got.size(), unstable_n, n);
                end
                for (int i = 0; i < got.size(); i++) begin
                    total++;
                    if (got[i] !== exp_rd[i]) begin
                        bad++;
                        $display("FAIL rand_rd%0d_%0d: got %h want %h", it, i, got[i], exp_rd[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = $urandom_range(0, 255);
        model_write(start, 3);
        obs_wr = {};
        send_frame(0);
        model_read(start, 3);
        send_frame(0);
        recv_bytes(3, -1, 0, 1'b0);
        total++;
        if (obs_wr.size() !== 3) begin
            bad++;
            $display("FAIL b2b_wr_count: got %0d want 3", obs_wr.size());
        end
        total++;
        if (got.size() !== 3) begin
            bad++;
            $display("FAIL b2b_rd_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== exp_rd[i]) begin
                bad++;
                $display("FAIL b2b_rd_%0d: got %h want %h", i, got[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int w;
        int rd0;
        model_read($urandom_range(0, 255), 4);
        send_frame(1);
        recv_bytes(2, -1, 0, 1'b0);
        total++;
        if (got.size() !== 2 || (got.size() == 2 && (got[0] !== exp_rd[0] || got[1] !== exp_rd[1]))) begin
            bad++;
            $display("FAIL rstmid_first_bytes: got %0d bytes want 2 matching model", got.size());
        end
        w = 0;
        @(negedge clk);
        while (tx_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_third_valid: got tx_valid=%b want 1", tx_valid);
        end
        @(posedge clk); #1;
        rst_n_sync = 1'b0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_immediate: got tx_valid=%b busy=%b want 0 0", tx_valid, busy);
        end
        rd0    = rd_en_count;
        obs_wr = {};
        repeat (2) @(posedge clk);
        #1;
        rst_n_sync = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (rd_en_count !== rd0 || obs_wr.size() !== 0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet: got rd_strobes=%0d wr_strobes=%0d tx_valid=%b busy=%b want 0 0 0 0",
                     rd_en_count - rd0, obs_wr.size(), tx_valid, busy);
        end
    endtask

    task automatic test_exclusive_strobes();
        total++;
        if (both_hi !== 0) begin
            bad++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", both_hi);
        end
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = 8'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        test_reset();
        test_write_single();
        test_read_burst();
        test_addr_wrap();
        test_rx_during_read();
        test_timeout();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_burst();
        test_exclusive_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
